// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg -- shared definitions for the pipelined floating-point multiplier.
//
// Holds the operand class enum, the bit positions inside the 4-bit exception
// flag vector, and the single-precision reference constants (bias, all-ones
// exponent, canonical quiet NaN).  Modules that are parameterised for other
// widths derive their own width-specific constants from E and M.
//
// Optional feature macro used by the multiplier: FP_MUL_RNE_EN.

package fp_mul_pkg;

    // Reference (binary32) format.
    localparam int DEF_E = 8;
    localparam int DEF_M = 23;

    localparam int                 BIAS     = (1 << (DEF_E - 1)) - 1;
    localparam logic [DEF_E-1:0]   EXP_ALL1 = {DEF_E{1'b1}};
    localparam logic [31:0]        QNAN     = 32'h7FC0_0000;

    // Operand classification after flush-to-zero of subnormal inputs.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // out_flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack -- splits an IEEE-754-style word into sign / exponent / mantissa
// and classifies it.  Subnormal encodings (exp == 0) are reported as ZERO so
// the multiplier treats them as zero (denormals-are-zero).
//
// Ports:
//   word  in   1+E+M  packed floating-point operand
//   sign  out  1      sign bit
//   exp   out  E      biased exponent field
//   man   out  M      stored mantissa field (no hidden bit)
//   cls   out  2      operand class (fp_class_e)

module fp_unpack
    import fp_mul_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic [E+M:0] word,
    output logic         sign,
    output logic [E-1:0] exp,
    output logic [M-1:0] man,
    output fp_class_e    cls
);

    assign sign = word[E+M];
    assign exp  = word[E+M-1:M];
    assign man  = word[M-1:0];

    always_comb begin
        cls = CLS_NORM;
        if (exp == '0) begin
            cls = CLS_ZERO;
        end else if (exp == {E{1'b1}}) begin
            cls = (man == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/float_multiplier_pipe.sv
// float_multiplier_pipe -- 3-stage pipelined IEEE-754-style multiplier with
// valid/ready flow control, special-value handling, flush-to-zero and flags.
//
// Optional feature: define FP_MUL_RNE_EN for round-to-nearest-even; without
// it the mantissa is truncated (round toward zero) and inexact is still set.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset (released synchronously)
//   in_valid   in   1           operand pair valid
//   in_ready   out  1           pipeline accepts a pair this cycle
//   in1, in2   in   DATA_WIDTH  operands
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts result
//   out        out  DATA_WIDTH  product
//   out_flags  out  4           {invalid, overflow, underflow, inexact}

module float_multiplier_pipe
    import fp_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic [3:0]            out_flags
);

    localparam int EW = E + 2;        // signed exponent-sum width
    localparam int PW = 2 * M + 2;    // significand product width

    localparam logic signed [EW-1:0] BIAS_S     = EW'((1 << (E - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_ALL1_S = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO_S = '0;
    localparam logic signed [EW-1:0] ONE_S      = EW'(1);

    localparam logic [DATA_WIDTH-1:0] QNAN_W = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

`ifdef FP_MUL_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    // Round-to-nearest-even increment; constant zero in truncation builds.
    function automatic logic round_up(input logic lsb, input logic g, input logic st);
        return RNE_EN & g & (st | lsb);
    endfunction

    // Pack a finite result, saturating to Inf on overflow and flushing to
    // signed zero on underflow.  Returns {flags, word}.
    function automatic logic [DATA_WIDTH+3:0] saturate(
        input logic                 sgn,
        input logic signed [EW-1:0] ex,
        input logic [M-1:0]         man,
        input logic                 inexact
    );
        logic [3:0]            f;
        logic [DATA_WIDTH-1:0] w;
        f = '0;
        if (ex >= EXP_ALL1_S) begin
            w                = {sgn, {E{1'b1}}, {M{1'b0}}};
            f[FLG_OVERFLOW]  = 1'b1;
            f[FLG_INEXACT]   = 1'b1;
        end else if (ex <= EXP_ZERO_S) begin
            w                = {sgn, {(E+M){1'b0}}};
            f[FLG_UNDERFLOW] = 1'b1;
            f[FLG_INEXACT]   = 1'b1;
        end else begin
            w                = {sgn, ex[E-1:0], man};
            f[FLG_INEXACT]   = inexact;
        end
        return {f, w};
    endfunction

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    logic [1:0] rst_sync;
    logic       rst_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    logic vld_p0, vld_p1, vld_p2;
    logic advance;

    // Whole pipeline moves as one; a held output freezes every stage.
    assign advance   = out_ready | ~vld_p2;
    assign in_ready  = advance & rst_ok;
    assign out_valid = vld_p2;

    // ---------------- S1: unpack, classify, exponent sum ----------------
    logic      sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] ma, mb;
    fp_class_e ca, cb;

    fp_unpack #(.E(E), .M(M)) u_unpack_a (.word(in1), .sign(sa), .exp(ea), .man(ma), .cls(ca));
    fp_unpack #(.E(E), .M(M)) u_unpack_b (.word(in2), .sign(sb), .exp(eb), .man(mb), .cls(cb));

    logic                 nan_s1, inf_s1, zero_s1;
    logic signed [EW-1:0] exp_s1;

    always_comb begin
        nan_s1  = (ca == CLS_NAN) | (cb == CLS_NAN) |
                  ((ca == CLS_INF) & (cb == CLS_ZERO)) |
                  ((ca == CLS_ZERO) & (cb == CLS_INF));
        inf_s1  = ((ca == CLS_INF) | (cb == CLS_INF)) & ~nan_s1;
        zero_s1 = ((ca == CLS_ZERO) | (cb == CLS_ZERO)) & ~nan_s1;
        exp_s1  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    end

    logic                 sign_p0, nan_p0, inf_p0, zero_p0;
    logic signed [EW-1:0] exp_p0;
    logic [M:0]           mana_p0, manb_p0;

    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p0 <= sa ^ sb;
            nan_p0  <= nan_s1;
            inf_p0  <= inf_s1;
            zero_p0 <= zero_s1;
            exp_p0  <= exp_s1;
            mana_p0 <= {1'b1, ma};
            manb_p0 <= {1'b1, mb};
        end
    end

    // ---------------- S2: significand product ----------------
    logic                 sign_p1, nan_p1, inf_p1, zero_p1;
    logic signed [EW-1:0] exp_p1;
    logic [PW-1:0]        prod_p1;

    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p1 <= sign_p0;
            nan_p1  <= nan_p0;
            inf_p1  <= inf_p0;
            zero_p1 <= zero_p0;
            exp_p1  <= exp_p0;
            prod_p1 <= PW'(mana_p0) * PW'(manb_p0);
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic                  hi_s3, guard_s3, sticky_s3, rnd_s3;
    logic [M-1:0]          mant_pre_s3;
    logic [M:0]            mant_rnd_s3;
    logic signed [EW-1:0]  ex_s3;
    logic [DATA_WIDTH-1:0] res_s3;
    logic [3:0]            flg_s3;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); MSB set means >= 2.
        hi_s3       = prod_p1[PW-1];
        mant_pre_s3 = hi_s3 ? prod_p1[PW-2 -: M] : prod_p1[PW-3 -: M];
        guard_s3    = hi_s3 ? prod_p1[M] : prod_p1[M-1];
        sticky_s3   = hi_s3 ? |prod_p1[M-1:0] : |prod_p1[M-2:0];
        rnd_s3      = round_up(mant_pre_s3[0], guard_s3, sticky_s3);
        mant_rnd_s3 = {1'b0, mant_pre_s3} + (M+1)'(rnd_s3);
        // A rounding carry leaves the field at zero and bumps the exponent.
        ex_s3       = exp_p1 + (hi_s3 ? ONE_S : EXP_ZERO_S)
                             + (mant_rnd_s3[M] ? ONE_S : EXP_ZERO_S);

        flg_s3 = '0;
        if (nan_p1) begin
            res_s3               = QNAN_W;
            flg_s3[FLG_INVALID]  = 1'b1;
        end else if (inf_p1) begin
            res_s3 = {sign_p1, {E{1'b1}}, {M{1'b0}}};
        end else if (zero_p1) begin
            res_s3 = {sign_p1, {(E+M){1'b0}}};
        end else begin
            {flg_s3, res_s3} = saturate(sign_p1, ex_s3, mant_rnd_s3[M-1:0],
                                        guard_s3 | sticky_s3);
        end
    end

    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out       <= '0;
            out_flags <= '0;
        end else if (advance) begin
            vld_p0    <= in_valid & in_ready;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out       <= res_s3;
            out_flags <= flg_s3;
        end
    end

endmodule

// File: tb/tb_float_multiplier_pipe.sv
// Scoreboard bench for float_multiplier_pipe (binary32 configuration).

module tb_float_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic [3:0]  out_flags;

    float_multiplier_pipe #(.DATA_WIDTH(32), .E(8), .M(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          issue;
        bit          lat;
        int          id;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idn   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Drive one pair; expected result goes to the scoreboard when it transfers.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input bit lat);
        int w;
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready) begin
            w++;
            if (w > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready stuck low for vector %0d", idn);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        sbq.push_back('{r, f, cyc + 1, lat, idn});
        idn++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sbq.size());
        end
    endtask

    // Monitor: compares every transferred result against the scoreboard head,
    // and checks that a stalled output holds and back-pressures the input.
    bit          prev_stall = 1'b0;
    logic [31:0] p_out;
    logic [3:0]  p_flags;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", in_ready, 0);
                    if (prev_stall) begin
                        check("stall_hold_out", out, p_out);
                        check("stall_hold_flags", out_flags, p_flags);
                    end
                end
                prev_stall = out_valid && !out_ready;
                p_out      = out;
                p_flags    = out_flags;
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_out: got %0h with no result pending", out);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check($sformatf("vec%0d_out", e.id), out, e.r);
                        check($sformatf("vec%0d_flags", e.id), out_flags, e.f);
                        if (e.lat) check($sformatf("vec%0d_latency", e.id), cyc + 1 - e.issue, 3);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", out_flags, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Basic product and latency on an idle pipeline.
        send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 1'b1);
        drain();

        // Rounding and special values.
`ifdef FP_MUL_RNE_EN
        send(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 4'b0001, 1'b1);
`else
        send(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 4'b0001, 1'b1);
`endif
        send(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 1'b1);
        send(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
        send(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1'b1);
        send(32'hFFC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
        send(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, 1'b1);
        send(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101, 1'b1);
        send(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000, 1'b1);
        send(32'h0080_0000, 32'h8080_0000, 32'h8000_0000, 4'b0011, 1'b1);
        send(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011, 1'b1);
        send(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000, 1'b1);
        send(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1'b1);
        drain();

        // Back-to-back stream with a 5-cycle downstream stall.
        fork
            begin
                send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 1'b0);
                send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 1'b0);
                send(32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 1'b0);
                send(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 4'b0000, 1'b0);
                send(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b0);
                send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pairs in flight.
        send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 1'b0);
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 1'b0);
        send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        check("inflight_rst_out_valid", out_valid, 0);
        check("inflight_rst_out", out, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_idle%0d", i), out_valid, 0);
        end

        send(32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 4'b0000, 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
